// File: rtl/rect_loop_feeder.sv
// rect_loop_feeder: assembles ROWS x COLS bit matrices from row beats into a
// two-slot ping-pong buffer and presents complete {param, matrix} frames to
// the loop stage. One slot can fill while the other is held by the consumer.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer keeps valid and its payload
// stable until that edge. m_valid does not depend on m_ready, and s_ready is
// decoded only from registered state, so neither ready depends combinationally
// on the other port.
module rect_loop_feeder #(
  parameter int ROWS    = 2,
  parameter int COLS    = 2,
  parameter int PARAM_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_first,
  input  logic [COLS-1:0]      s_row,
  input  logic [PARAM_W-1:0]   s_param,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PARAM_W-1:0]   m_param,
  output logic [ROWS*COLS-1:0] m_mat,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int MAT_W  = ROWS * COLS;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

  logic [1:0]         slot_full_q, slot_full_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  logic [RIDX_W-1:0]  row_idx_q, row_idx_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               err_q, err_d;
  logic [PARAM_W-1:0] slot_param_q [2];
  logic [PARAM_W-1:0] slot_param_d [2];
  logic [MAT_W-1:0]   slot_mat_q [2];
  logic [MAT_W-1:0]   slot_mat_d [2];

  logic               accept;
  logic               drain;
  logic               err_set;
  logic [RIDX_W-1:0]  store_idx;

  // Ready/valid and output payload are pure decodes of the registered slots.
  assign s_ready   = ~slot_full_q[wr_sel_q];
  assign m_valid   = slot_full_q[rd_sel_q];
  assign m_param   = slot_param_q[rd_sel_q];
  assign m_mat     = slot_mat_q[rd_sel_q];
  assign frame_cnt = frame_cnt_q;
  assign err       = err_q;

  assign accept = s_valid & s_ready;
  assign drain  = m_valid & m_ready;

  // Next-state: fill side writes slot wr_sel, drain side frees slot rd_sel.
  // A fill only targets an empty slot and a drain only a full one, so the two
  // never touch the same slot in one cycle.
  always_comb begin
    slot_full_d  = slot_full_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    row_idx_d    = row_idx_q;
    frame_cnt_d  = frame_cnt_q;
    slot_param_d = slot_param_q;
    slot_mat_d   = slot_mat_q;
    err_set      = 1'b0;
    store_idx    = row_idx_q;

    if (drain) begin
      slot_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = ~rd_sel_q;
    end

    if (accept) begin
      if ((row_idx_q == '0) && !s_first) begin
        // Stray continuation beat with no frame open: drop it.
        err_set = 1'b1;
      end else begin
        if (s_first) begin
          // A first beat mid-frame abandons the partial frame; later rows
          // overwrite whatever the abandoned frame left in the slot.
          err_set                = (row_idx_q != '0);
          store_idx              = '0;
          slot_param_d[wr_sel_q] = s_param;
        end
        slot_mat_d[wr_sel_q][int'(store_idx)*COLS +: COLS] = s_row;
        if (store_idx == LAST_ROW) begin
          slot_full_d[wr_sel_q] = 1'b1;
          wr_sel_d              = ~wr_sel_q;
          row_idx_d             = '0;
          frame_cnt_d           = frame_cnt_q + CNT_W'(1);
        end else begin
          row_idx_d = store_idx + RIDX_W'(1);
        end
      end
    end

    // Setting the sticky flag wins over a same-cycle clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State register with synchronous active-low reset; reset discards all frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_full_q <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      row_idx_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_param_q[i] <= '0;
        slot_mat_q[i]   <= '0;
      end
    end else begin
      slot_full_q  <= slot_full_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      row_idx_q    <= row_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      slot_param_q <= slot_param_d;
      slot_mat_q   <= slot_mat_d;
    end
  end

endmodule

// File: tb/tb_rect_loop_feeder.sv
// Testbench for rect_loop_feeder: directed scenarios followed by random
// traffic, all checked against a frame-queue reference model.
module tb_rect_loop_feeder;

  localparam int ROWS    = 2;
  localparam int COLS    = 2;
  localparam int PARAM_W = 12;
  localparam int CNT_W   = 4;
  localparam int MAT_W   = ROWS * COLS;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic               s_first = 1'b0;
  logic [COLS-1:0]    s_row = '0;
  logic [PARAM_W-1:0] s_param = '0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [PARAM_W-1:0] m_param;
  logic [MAT_W-1:0]   m_mat;
  logic [CNT_W-1:0]   frame_cnt;
  logic               err;
  logic               err_clr = 1'b0;

  always #5 clk = ~clk;

  rect_loop_feeder #(
    .ROWS(ROWS), .COLS(COLS), .PARAM_W(PARAM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_first(s_first),
    .s_row(s_row), .s_param(s_param),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_param(m_param), .m_mat(m_mat),
    .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
  );

  // ---------------- reference model ----------------
  // exp_q holds completed, not yet consumed frames as {param, matrix}.
  logic [PARAM_W+MAT_W-1:0] exp_q[$];
  logic [COLS-1:0]          part_rows [ROWS];
  int                       part_cnt = 0;
  logic [PARAM_W-1:0]       part_param = '0;
  logic                     exp_err = 1'b0;
  logic [CNT_W-1:0]         exp_cnt = '0;
  bit                       model_live = 0;
  bit                       last_accept = 0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [MAT_W-1:0] pack_rows();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m[r*COLS + c] = part_rows[r][c];
    return m;
  endfunction

  task automatic check_outputs();
    logic [PARAM_W+MAT_W-1:0] head;
    if (!model_live) return;
    check("s_ready", s_ready, exp_q.size() < 2);
    check("m_valid", m_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("m_param", m_param, head[PARAM_W+MAT_W-1:MAT_W]);
      check("m_mat", m_mat, head[MAT_W-1:0]);
    end
    check("frame_cnt", frame_cnt, exp_cnt);
    check("err", err, exp_err);
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    bit rdy;
    bit set;
    if (!reset) begin
      exp_q.delete();
      part_cnt    = 0;
      exp_err     = 1'b0;
      exp_cnt     = '0;
      model_live  = 1;
      last_accept = 0;
      return;
    end
    rdy = (exp_q.size() < 2);
    last_accept = s_valid && rdy;
    set = 0;
    if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
    if (last_accept) begin
      if (part_cnt == 0 && !s_first) begin
        set = 1;
      end else begin
        if (s_first) begin
          if (part_cnt != 0) set = 1;
          part_cnt   = 0;
          part_param = s_param;
        end
        part_rows[part_cnt] = s_row;
        part_cnt++;
        if (part_cnt == ROWS) begin
          exp_q.push_back({part_param, pack_rows()});
          part_cnt = 0;
          exp_cnt  = exp_cnt + 1'b1;
        end
      end
    end
    if (set) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drive, check at negedge, model the edge, advance.
  task automatic cycle(input logic v, input logic f, input logic [COLS-1:0] row,
                       input logic [PARAM_W-1:0] p, input logic mr,
                       input logic clr, input logic rst);
    s_valid = v; s_first = f; s_row = row; s_param = p;
    m_ready = mr; err_clr = clr; reset = rst;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input logic f, input logic [COLS-1:0] row,
                           input logic [PARAM_W-1:0] p, input logic mr);
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, f, row, p, mr, 1'b0, 1'b1);
      tries++;
    end while (!last_accept && tries < 20);
    if (!last_accept) check("beat_accept_timeout", last_accept, 1);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, mr, 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [PARAM_W-1:0] p, input logic mr);
    send_beat(1'b1, COLS'($urandom), p, mr);
    for (int r = 1; r < ROWS; r++) send_beat(1'b0, COLS'($urandom), '0, mr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("reset_m_valid", m_valid, 0);
    check("reset_s_ready", s_ready, 1);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_err", err, 0);

    // Basic 2x2 frame
    send_beat(1'b1, 2'b01, 12'h0A5, 1'b0);
    send_beat(1'b0, 2'b10, 12'h000, 1'b0);
    check("t1_m_valid", m_valid, 1);
    check("t1_m_mat", m_mat, 4'b1001);
    check("t1_m_param", m_param, 12'h0A5);
    check("t1_frame_cnt", frame_cnt, 1);
    idle(1, 1'b1);

    // Back-pressure: two frames buffered, third stalls, then all drain in order
    send_frame(12'h101, 1'b0);
    send_frame(12'h202, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t2_full_s_ready", s_ready, 0);
      cycle(1'b1, 1'b1, 2'b11, 12'h303, 1'b0, 1'b0, 1'b1);
    end
    send_beat(1'b1, 2'b11, 12'h303, 1'b1);
    send_beat(1'b0, 2'b01, 12'h000, 1'b1);
    idle(4, 1'b1);
    check("t2_drained", m_valid, 0);

    // Stray continuation beat while idle
    cycle(1'b1, 1'b0, 2'b11, 12'h000, 1'b1, 1'b0, 1'b1);
    check("t3_err", err, 1);
    check("t3_no_valid", m_valid, 0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    check("t3_err_clr", err, 0);

    // Restart mid-frame
    send_beat(1'b1, 2'b11, 12'h111, 1'b1);
    send_beat(1'b1, 2'b10, 12'h3FF, 1'b1);
    check("t4_err", err, 1);
    send_beat(1'b0, 2'b01, 12'h000, 1'b0);
    check("t4_m_param", m_param, 12'h3FF);
    check("t4_m_mat", m_mat, 4'b0110);
    idle(1, 1'b1);

    // Reset mid-frame with a buffered frame and err set
    send_frame(12'h055, 1'b0);
    send_beat(1'b1, 2'b10, 12'h066, 1'b0);
    check("t5_pre_valid", m_valid, 1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_m_valid", m_valid, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_err", err, 0);
    check("t5_s_ready", s_ready, 1);

    // Continuous streaming past the counter wrap
    c0 = cyc;
    for (int f = 0; f < (1 << CNT_W) + 1; f++) send_frame(PARAM_W'(f), 1'b1);
    check("t6_stream_cycles", cyc - c0, ((1 << CNT_W) + 1) * ROWS);
    check("t6_cnt_wrap", frame_cnt, 1);
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic v, f, mr, clr, rst;
      v   = ($urandom_range(0, 9) < 7);
      f   = (part_cnt == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      mr  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) != 0);
      cycle(v, f, COLS'($urandom), PARAM_W'($urandom), mr, clr, rst);
    end
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
